// File: rtl/irrigation_pkg.sv
// Shared state encoding and default timing constants for irrigation control stages.
package irrigation_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SPRINKLE = 3'd1,
    S_DRIP     = 3'd2,
    S_COOL     = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam int DEF_MIN_ON     = 8;
  localparam int DEF_MAX_ON     = 64;
  localparam int DEF_COOLDOWN   = 4;
  localparam int DEF_BLINK_HALF = 2;

  // Timer only ever reaches MAX_ON-1, so this width never wraps.
  function automatic int timer_width(input int max_on);
    return $clog2(max_on + 1);
  endfunction

endpackage

// File: rtl/irrigation_timer.sv
// Clear/enable up-counter with terminal-compare outputs, shared by run, cool and blink phases.
module irrigation_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] floor,
  output logic [W-1:0] count,
  output logic         at_limit,
  output logic         at_floor
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);
  assign at_floor = (count >= floor);

endmodule

// File: rtl/irrigation_sequencer.sv
// Timed actuator stage: registers raw irrigation requests and drives valve, sprinkler,
// dripper and a blinking fault alarm with min/max run times and a cooldown gap.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int MIN_ON     = DEF_MIN_ON,
  parameter int MAX_ON     = DEF_MAX_ON,
  parameter int COOLDOWN   = DEF_COOLDOWN,
  parameter int BLINK_HALF = DEF_BLINK_HALF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       error_in,
  input  logic       supply_req,
  input  logic       asp_req,
  input  logic       got_req,
  input  logic       alarm_ack,
  output logic       valve_on,
  output logic       sprinkler_on,
  output logic       dripper_on,
  output logic       alarm_out,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int TW = timer_width(MAX_ON);
  localparam logic [TW-1:0] RUN_LAST   = TW'(MAX_ON - 1);
  localparam logic [TW-1:0] MIN_LAST   = TW'(MIN_ON - 1);
  localparam logic [TW-1:0] COOL_LAST  = TW'(COOLDOWN - 1);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_HALF - 1);

  state_t state, next_state;
  logic error_q, supply_q, asp_q, got_q, ack_q;
  logic blink, blink_next;

  logic          timer_clear, timer_en;
  logic [TW-1:0] timer_limit;
  logic [TW-1:0] timer_count;
  logic          timer_at_limit, timer_at_floor;
  logic          own_q;

  irrigation_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .enable   (timer_en),
    .limit    (timer_limit),
    .floor    (MIN_LAST),
    .count    (timer_count),
    .at_limit (timer_at_limit),
    .at_floor (timer_at_floor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      blink    <= 1'b0;
      error_q  <= 1'b0;
      supply_q <= 1'b0;
      asp_q    <= 1'b0;
      got_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state    <= next_state;
      blink    <= blink_next;
      error_q  <= error_in;
      supply_q <= supply_req;
      asp_q    <= asp_req;
      got_q    <= got_req;
      ack_q    <= alarm_ack;
    end
  end

  // The running actuator only watches its own request; the other one waits for IDLE.
  assign own_q = (state == S_SPRINKLE) ? asp_q : got_q;

  always_comb begin
    next_state  = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    timer_limit = '0;
    blink_next  = 1'b0;
    unique case (state)
      S_IDLE: begin
        timer_clear = 1'b1;
        if (asp_q) begin
          next_state = S_SPRINKLE;
        end else if (got_q) begin
          next_state = S_DRIP;
        end
      end
      S_SPRINKLE, S_DRIP: begin
        timer_limit = RUN_LAST;
        if (timer_at_limit || (!own_q && timer_at_floor)) begin
          next_state  = S_COOL;
          timer_clear = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_COOL: begin
        timer_limit = COOL_LAST;
        if (timer_at_limit) begin
          next_state  = S_IDLE;
          timer_clear = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_FAULT: begin
        timer_limit = BLINK_LAST;
        blink_next  = blink;
        if (ack_q && !error_q) begin
          next_state  = S_IDLE;
          timer_clear = 1'b1;
          blink_next  = 1'b0;
        end else if (timer_at_limit) begin
          timer_clear = 1'b1;
          blink_next  = ~blink;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        next_state  = S_IDLE;
        timer_clear = 1'b1;
      end
    endcase
    // A persisting error inside FAULT must not restart the blink timer.
    if (error_q && (state != S_FAULT)) begin
      next_state  = S_FAULT;
      timer_clear = 1'b1;
      timer_en    = 1'b0;
      blink_next  = 1'b1;
    end
  end

  assign sprinkler_on = (state == S_SPRINKLE);
  assign dripper_on   = (state == S_DRIP);
  assign alarm_out    = (state == S_FAULT) && blink;
  assign valve_on     = supply_q && (state != S_FAULT);
  assign busy         = (state != S_IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with default timing parameters.
module tb_irrigation_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       error_in = 1'b0;
  logic       supply_req = 1'b0;
  logic       asp_req = 1'b0;
  logic       got_req = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       valve_on, sprinkler_on, dripper_on, alarm_out, busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  localparam int TRACE_N = 160;
  logic spr_t [0:TRACE_N-1];
  logic drp_t [0:TRACE_N-1];
  logic bsy_t [0:TRACE_N-1];
  logic [7:0] pat;

  irrigation_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .error_in     (error_in),
    .supply_req   (supply_req),
    .asp_req      (asp_req),
    .got_req      (got_req),
    .alarm_ack    (alarm_ack),
    .valve_on     (valve_on),
    .sprinkler_on (sprinkler_on),
    .dripper_on   (dripper_on),
    .alarm_out    (alarm_out),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index i holds the outputs right after edge E_i; requests are high before E_0..E_{len-1}.
  task automatic capture(input int n, input int asp_len, input int got_len);
    for (int i = 0; i < TRACE_N; i++) begin
      spr_t[i] = 1'b0;
      drp_t[i] = 1'b0;
      bsy_t[i] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      asp_req = (i < asp_len);
      got_req = (i < got_len);
      tick();
      spr_t[i] = sprinkler_on;
      drp_t[i] = dripper_on;
      bsy_t[i] = busy;
    end
    asp_req = 1'b0;
    got_req = 1'b0;
  endtask

  function automatic logic trace_bit(input int sel, input int i);
    if (sel == 0) return spr_t[i];
    if (sel == 1) return drp_t[i];
    return bsy_t[i];
  endfunction

  function automatic int next_rise(input int sel, input int from);
    for (int i = from; i < TRACE_N; i++) begin
      if (trace_bit(sel, i)) return i;
    end
    return -1;
  endfunction

  function automatic int run_len(input int sel, input int start);
    int n;
    n = 0;
    if (start < 0) return 0;
    for (int i = start; i < TRACE_N; i++) begin
      if (!trace_bit(sel, i)) break;
      n++;
    end
    return n;
  endfunction

  initial begin
    #1;
    check("rst_sprinkler", {31'd0, sprinkler_on}, 32'd0);
    check("rst_valve", {31'd0, valve_on}, 32'd0);
    check("rst_alarm", {31'd0, alarm_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", {29'd0, state_dbg}, 32'd0);

    // 1-cycle pulse: MIN_ON clamp, then 4 cooldown cycles.
    capture(20, 1, 0);
    check("t1_spr_start", next_rise(0, 0), 1);
    check("t1_spr_len", run_len(0, 1), 8);
    check("t1_busy_len", run_len(2, 1), 12);
    check("t1_busy_end", {31'd0, bsy_t[13]}, 32'd0);

    // Held 100: 64 cap, 4 cool + 1 idle re-arbitration, restart runs to request end (E100).
    capture(110, 100, 0);
    check("t2_run1_start", next_rise(0, 0), 1);
    check("t2_run1_len", run_len(0, 1), 64);
    check("t2_idle_gap", {31'd0, bsy_t[69]}, 32'd0);
    check("t2_run2_start", next_rise(0, 65), 70);
    check("t2_run2_len", run_len(0, 70), 31);
    check("t2_busy_end", {31'd0, bsy_t[105]}, 32'd0);

    // Both requests: sprinkler wins; dripper starts after cooldown and is held to MIN_ON.
    capture(45, 20, 30);
    check("t3_spr_start", next_rise(0, 0), 1);
    check("t3_spr_len", run_len(0, 1), 20);
    check("t3_drp_start", next_rise(1, 0), 26);
    check("t3_drp_len", run_len(1, 26), 8);
    check("t3_busy_end", {31'd0, bsy_t[38]}, 32'd0);

    // Error during sprinkle at timer=3.
    asp_req = 1'b1;
    repeat (4) tick();
    error_in = 1'b1;
    tick();
    check("t4_spr_at_err", {31'd0, sprinkler_on}, 32'd1);
    asp_req = 1'b0;
    tick();
    check("t4_spr_off", {31'd0, sprinkler_on}, 32'd0);
    check("t4_fault_state", {29'd0, state_dbg}, 32'd4);
    pat[7] = alarm_out;
    for (int i = 6; i >= 0; i--) begin
      tick();
      pat[i] = alarm_out;
    end
    check("t4_blink_pattern", {24'd0, pat}, 32'hCC);
    alarm_ack = 1'b1;
    repeat (3) tick();
    check("t4_ack_with_err", {31'd0, busy}, 32'd1);
    alarm_ack = 1'b0;
    error_in = 1'b0;
    repeat (3) tick();
    check("t4_err_clear_no_ack", {31'd0, busy}, 32'd1);
    alarm_ack = 1'b1;
    tick();
    check("t4_ack_sampled", {31'd0, busy}, 32'd1);
    alarm_ack = 1'b0;
    tick();
    check("t4_exit_busy", {31'd0, busy}, 32'd0);
    check("t4_exit_alarm", {31'd0, alarm_out}, 32'd0);

    // Valve follows registered supply request except in FAULT.
    supply_req = 1'b1;
    check("t5_valve_before", {31'd0, valve_on}, 32'd0);
    tick();
    check("t5_valve_on", {31'd0, valve_on}, 32'd1);
    error_in = 1'b1;
    tick();
    check("t5_valve_pre_fault", {31'd0, valve_on}, 32'd1);
    tick();
    check("t5_valve_fault", {31'd0, valve_on}, 32'd0);
    check("t5_alarm_fault", {31'd0, alarm_out}, 32'd1);
    error_in = 1'b0;
    alarm_ack = 1'b1;
    tick();
    tick();
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    check("t5_valve_back", {31'd0, valve_on}, 32'd1);
    alarm_ack = 1'b0;
    supply_req = 1'b0;
    tick();
    check("t5_valve_off", {31'd0, valve_on}, 32'd0);

    // Asynchronous reset in the middle of a drip run (timer=5).
    got_req = 1'b1;
    supply_req = 1'b1;
    repeat (7) tick();
    check("t6_drip_running", {31'd0, dripper_on}, 32'd1);
    check("t6_valve_running", {31'd0, valve_on}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_dripper", {31'd0, dripper_on}, 32'd0);
    check("t6_async_valve", {31'd0, valve_on}, 32'd0);
    check("t6_async_busy", {31'd0, busy}, 32'd0);
    got_req = 1'b0;
    supply_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    check("t6_idle_dripper", {31'd0, dripper_on}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
